seq_adder_32bit: RTL and testbench

Multi-cycle 32-bit adder built around a single 8-bit slice adder with a registered carry. It is the additive counterpart of the combinational 8-bit-chunk ripple subtractor. It processes one byte per clock, LSB first, behind a start/busy/done handshake. It is intended for the datapath where one adder slice is shared to save area instead of rippling four slices combinationally.

---
 rtl/seq_adder_32bit_if.sv | 25 ++
 rtl/seq_adder_32bit.sv | 116 +++++++++++
 tb/tb_seq_adder_32bit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seq_adder_32bit_if.sv
// Handshake and operand/result bundle for the byte-serial adder.
// The master issues start with operands; the slave returns the result and status.
interface seq_adder_32bit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, Cin,
    input  Sum, Cout, Ovf, busy, done
  );

  modport slave (
    input  start, A, B, Cin,
    output Sum, Cout, Ovf, busy, done
  );
endinterface

// File: rtl/seq_adder_32bit.sv
// Multi-cycle adder: one SLICE-bit adder is reused over NSLICE cycles, LSB slice
// first, with the inter-slice carry held in a register. The result registers
// only update when the last slice completes, so no partial sum is ever visible.
module seq_adder_32bit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic            clk,
  input logic            rst,
  seq_adder_32bit_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [SLICE:0]   slice_res;
  logic             last_slice;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // The single shared slice adder and the accumulator with the current slice merged in.
  always_comb begin
    slice_res  = {1'b0, op_a[idx*SLICE +: SLICE]} + {1'b0, op_b[idx*SLICE +: SLICE]}
               + {{SLICE{1'b0}}, carry};
    acc_next   = acc;
    acc_next[idx*SLICE +: SLICE] = slice_res[SLICE-1:0];
    last_slice = (idx == LAST_IDX);
  end

  // State register.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and Moore status outputs.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    unique case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-slice accumulation and final result registration.
  // NOTE: all datapath registers are reset so an aborted run leaves no stale operands behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a  <= bus.A;
            op_b  <= bus.B;
            carry <= bus.Cin;
            acc   <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= slice_res[SLICE];
          idx   <= idx + 1'b1;
          if (last_slice) begin
            sum_q  <= acc_next;
            cout_q <= slice_res[SLICE];
            ovf_q  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (acc_next[WIDTH-1] != op_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
  assign bus.Ovf  = ovf_q;

endmodule

// File: tb/tb_seq_adder_32bit.sv
// Self-checking bench for seq_adder_32bit: directed corner cases plus random
// operands, compared against a plain-arithmetic model of A+B+Cin.
module tb_seq_adder_32bit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_adder_32bit_if #(.WIDTH(32)) bus ();

  seq_adder_32bit #(.WIDTH(32), .SLICE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] last_sum;
  logic        last_cout;
  logic        last_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned sum for Sum/Cout, true signed range test for Ovf.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       output logic [31:0] sum, output logic cout, output logic ovf);
    longint ua, ub, u, sa, sb, s;
    ua   = longint'({32'd0, a});
    ub   = longint'({32'd0, b});
    u    = ua + ub + longint'(cin);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    s    = sa + sb + longint'(cin);
    sum  = u[31:0];
    cout = u[32];
    ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction. With disturb set, inputs are scrambled and a second start
  // is pulsed mid-run; neither may affect the result or launch another run.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input bit disturb);
    logic [31:0] exp_sum;
    logic        exp_cout, exp_ovf;
    int          n, busy_cycles;
    model(a, b, cin, exp_sum, exp_cout, exp_ovf);
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    busy_cycles = 0;
    while (!bus.done && n < 12) begin
      if (bus.busy) busy_cycles++;
      check({tag, " hold_sum"}, 64'(bus.Sum), 64'(last_sum));
      if (disturb) begin
        bus.A   = $urandom;
        bus.B   = $urandom;
        bus.Cin = ~bus.Cin;
        if (n == 1) begin
          bus.start = 1'b1;
          bus.A     = 32'hFFFF_FFFF;
          bus.B     = 32'hFFFF_FFFF;
        end
        if (n == 2) bus.start = 1'b0;
      end
      tick();
      n++;
    end
    if (bus.busy) busy_cycles++;
    check({tag, " done_latency"}, 64'(n), 64'd4);
    check({tag, " sum"},  64'(bus.Sum),  64'(exp_sum));
    check({tag, " cout"}, 64'(bus.Cout), 64'(exp_cout));
    check({tag, " ovf"},  64'(bus.Ovf),  64'(exp_ovf));
    check({tag, " busy_cycles"}, 64'(busy_cycles), 64'd5);
    last_sum  = exp_sum;
    last_cout = exp_cout;
    last_ovf  = exp_ovf;
    tick();
    check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, " idle"},       64'(bus.busy), 64'd0);
    check({tag, " held"},       64'(bus.Sum),  64'(last_sum));
  endtask

  initial begin
    int          done_cycle[$];
    logic [31:0] ra, rb;
    logic        rc;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    repeat (2) tick();
    check("reset sum",  64'(bus.Sum),  64'd0);
    check("reset cout", 64'(bus.Cout), 64'd0);
    check("reset ovf",  64'(bus.Ovf),  64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    tick();
    check("post_reset busy", 64'(bus.busy), 64'd0);

    run_op("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    run_op("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    run_op("t3a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("t3a ovf_const", 64'(bus.Ovf), 64'd1);
    run_op("t3b", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    check("t3b sum_const", 64'(bus.Sum), 64'd0);
    check("t3b cout_const", 64'(bus.Cout), 64'd1);
    run_op("t4", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    check("t4 sum_const", 64'(bus.Sum), 64'h2345_6789);

    // Reset during the third RUN cycle aborts and clears the visible outputs.
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h0101_0101;
    bus.Cin   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t5 busy", 64'(bus.busy), 64'd0);
    check("t5 done", 64'(bus.done), 64'd0);
    check("t5 sum",  64'(bus.Sum),  64'd0);
    check("t5 cout", 64'(bus.Cout), 64'd0);
    check("t5 ovf",  64'(bus.Ovf),  64'd0);
    tick();
    rst = 1'b0;
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    tick();
    run_op("t5b", 32'd5, 32'd7, 1'b0, 1'b0);

    // Start held high: done every 6 cycles, result stable in between.
    bus.A     = 32'h0000_0010;
    bus.B     = 32'h0000_0020;
    bus.Cin   = 1'b0;
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 40 && done_cycle.size() < 4; cyc++) begin
      tick();
      if (bus.done) begin
        done_cycle.push_back(cyc);
        check("t6 sum_at_done", 64'(bus.Sum), 64'h30);
      end else if (done_cycle.size() > 0) begin
        check("t6 sum_stable", 64'(bus.Sum), 64'h30);
      end
    end
    bus.start = 1'b0;
    check("t6 pulse_count", 64'(done_cycle.size()), 64'd4);
    for (int i = 1; i < done_cycle.size(); i++)
      check("t6 period", 64'(done_cycle[i] - done_cycle[i-1]), 64'd6);
    for (int i = 0; i < 8 && bus.busy; i++) tick();
    check("t6 back_idle", 64'(bus.busy), 64'd0);
    last_sum = 32'h0000_0030;

    // Random operands, every other one with mid-run disturbance.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      if (i % 6 == 0) rb = ~ra;
      run_op($sformatf("rand%0d", i), ra, rb, rc, (i % 2) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
